uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx_cfg.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state codes, parity encodings, data-bit decode.
// Declarations only; no latency.
// No flow control involved.
package uart_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;

    // parity_mode codes 2'b00 and 2'b11 both mean "no parity"
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // data_bits code 00..11 maps to 5..8 data bits per frame
    function automatic logic [3:0] decode_data_bits(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO holding received words {ferr, perr, data}.
// Write visible at the head one clock after wr; read pops on the clock edge.
// Writes while full are ignored unless a pop happens on the same edge.
module uart_rx_fifo #(
    parameter int WIDTH      = 10,
    parameter int ADDR_WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] w_data,
    input  logic             rd,
    output logic [WIDTH-1:0] r_data,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0]      mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_en;
    logic                  rd_en;

    // A pop frees the head slot in the same edge, so write-while-full is legal with a read.
    assign rd_en  = rd & ~empty;
    assign wr_en  = wr & (~full | rd_en);
    assign r_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents only matter behind the valid pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= w_data;
    end

    // Pointer and status flag update; pointers wrap naturally at 2**ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            case ({wr_en, rd_en})
                2'b10: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    empty  <= 1'b0;
                    full   <= (wr_ptr + 1'b1 == rd_ptr);
                end
                2'b01: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    full   <= 1'b0;
                    empty  <= (rd_ptr + 1'b1 == wr_ptr);
                end
                2'b11: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5-8 data bits, none/even/odd parity, 1-2 stop bits) with a receive FIFO.
// Word reaches the FIFO head one clock after rx_done_tick, mid-way through the last stop bit.
// No backpressure on the line: frames arriving while the FIFO is full are dropped and flagged in overrun.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT_MAX   = 8,
    parameter int SB_TICK    = 16,
    parameter int ADDR_WIDTH = 2,
    parameter int DVSR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DVSR_WIDTH-1:0] dvsr,
    input  logic [1:0]            data_bits,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2,
    input  logic                  rx,
    input  logic                  rd_uart,
    input  logic                  clr_ovr,
    output logic [DBIT_MAX-1:0]   r_data,
    output logic                  r_perr,
    output logic                  r_ferr,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic                  overrun,
    output logic                  rx_done_tick
);

    localparam int SW = $clog2(SB_TICK);
    localparam int NW = $clog2(DBIT_MAX + 1);
    localparam logic [SW-1:0] S_MID = SW'(SB_TICK / 2 - 1);
    localparam logic [SW-1:0] S_END = SW'(SB_TICK - 1);

    logic                  rx_meta, rx_sync, armed;
    logic [1:0]            sync_warm;
    logic [DVSR_WIDTH-1:0] baud_cnt;
    logic                  tick;
    rx_state_t             state;
    logic [SW-1:0]         s;
    logic [NW-1:0]         n;
    logic [DBIT_MAX-1:0]   shreg, data_al;
    logic                  par_bit, ferr, stop_cnt;
    logic [NW-1:0]         cfg_nbits, shamt;
    logic [1:0]            cfg_par;
    logic                  cfg_stop2;
    logic                  par_en, par_xor, perr_calc;
    logic                  done;
    logic [DBIT_MAX+1:0]   wr_word, head;

    // Synchroniser; 'armed' waits until the real line has been seen high, so a line
    // that is still low when reset lifts does not look like a start bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            sync_warm <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            sync_warm <= {sync_warm[0], 1'b1};
            if (sync_warm[1] && rx_sync) armed <= 1'b1;
        end
    end

    // Free-running oversample tick generator, one tick every dvsr+1 clocks.
    always_ff @(posedge clk) begin
        if (!reset_n)              baud_cnt <= '0;
        else if (baud_cnt >= dvsr) baud_cnt <= '0;
        else                       baud_cnt <= baud_cnt + 1'b1;
    end

    assign tick      = (baud_cnt == dvsr);
    assign par_en    = (cfg_par == PAR_EVEN) || (cfg_par == PAR_ODD);
    assign shamt     = NW'(DBIT_MAX) - cfg_nbits;
    assign data_al   = shreg >> shamt;
    assign par_xor   = (^data_al) ^ par_bit;
    assign perr_calc = par_en & ((cfg_par == PAR_EVEN) ? par_xor : ~par_xor);

    // Frame FSM: mid-bit sampling, config latched on leaving IDLE, result word built at the last stop sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            s         <= '0;
            n         <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            ferr      <= 1'b0;
            stop_cnt  <= 1'b0;
            cfg_nbits <= '0;
            cfg_par   <= 2'b00;
            cfg_stop2 <= 1'b0;
            done      <= 1'b0;
            wr_word   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (armed && !rx_sync) begin
                        state     <= ST_START;
                        s         <= '0;
                        cfg_nbits <= NW'(decode_data_bits(data_bits));
                        cfg_par   <= parity_mode;
                        cfg_stop2 <= stop2;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (s == S_MID) begin
                            if (!rx_sync) begin
                                state    <= ST_DATA;
                                s        <= '0;
                                n        <= '0;
                                shreg    <= '0;
                                ferr     <= 1'b0;
                                stop_cnt <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (s == S_END) begin
                            s     <= '0;
                            shreg <= {rx_sync, shreg[DBIT_MAX-1:1]};
                            if (n == cfg_nbits - 1'b1) state <= par_en ? ST_PARITY : ST_STOP;
                            else                       n     <= n + 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (s == S_END) begin
                            s       <= '0;
                            par_bit <= rx_sync;
                            state   <= ST_STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (s == S_END) begin
                            s <= '0;
                            if (cfg_stop2 && !stop_cnt) begin
                                stop_cnt <= 1'b1;
                                ferr     <= ferr | ~rx_sync;
                            end else begin
                                state   <= ST_IDLE;
                                done    <= 1'b1;
                                wr_word <= {ferr | ~rx_sync, perr_calc, data_al};
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overrun: a completed frame found no room; a new drop wins over clr_ovr.
    always_ff @(posedge clk) begin
        if (!reset_n)                          overrun <= 1'b0;
        else if (done && rx_full && !rd_uart) overrun <= 1'b1;
        else if (clr_ovr)                      overrun <= 1'b0;
    end

    uart_rx_fifo #(
        .WIDTH      (DBIT_MAX + 2),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (done),
        .w_data  (wr_word),
        .rd      (rd_uart),
        .r_data  (head),
        .empty   (rx_empty),
        .full    (rx_full)
    );

    assign r_data       = head[DBIT_MAX-1:0];
    assign r_perr       = head[DBIT_MAX];
    assign r_ferr       = head[DBIT_MAX+1];
    assign rx_done_tick = done;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: serial frames driven from a bit-level generator,
// expected words tracked as a queue-based FIFO model, checked every cycle.
// Directed scenarios pin the model with literal values; a random phase mixes configs, errors and reads.
module tb_uart_rx_cfg;

    localparam int SB_TICK = 16;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] dvsr = 11'd10;
    logic [1:0]  data_bits = 2'b11;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop2 = 1'b0;
    logic        rx = 1'b1;
    logic        rd_uart = 1'b0;
    logic        clr_ovr = 1'b0;
    logic [7:0]  r_data;
    logic        r_perr, r_ferr, rx_empty, rx_full, overrun, rx_done_tick;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int sent_count = 0;
    bit rand_on = 1'b0;
    bit finished = 1'b0;

    logic [9:0] exp_frames[$];   // frames on the wire whose done pulse is still due
    logic [9:0] model_q[$];      // expected FIFO contents, head first
    logic       model_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_cfg dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dvsr         (dvsr),
        .data_bits    (data_bits),
        .parity_mode  (parity_mode),
        .stop2        (stop2),
        .rx           (rx),
        .rd_uart      (rd_uart),
        .clr_ovr      (clr_ovr),
        .r_data       (r_data),
        .r_perr       (r_perr),
        .r_ferr       (r_ferr),
        .rx_empty     (rx_empty),
        .rx_full      (rx_full),
        .overrun      (overrun),
        .rx_done_tick (rx_done_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    function automatic int bit_time();
        return SB_TICK * (int'(dvsr) + 1);
    endfunction

    // Drive one frame using the current config; optionally scramble config mid-start-bit.
    task automatic send_frame(input logic [7:0] d, input bit flip, input bit bad_stop, input bit scramble);
        int         bt, nb;
        logic [7:0] dm, mask;
        logic       pb, par_on;
        logic [1:0] db_s, pm_s;
        logic       s2_s;
        bt     = bit_time();
        nb     = 5 + int'(data_bits);
        mask   = 8'((1 << nb) - 1);
        dm     = d & mask;
        par_on = (parity_mode == 2'b01) || (parity_mode == 2'b10);
        pb     = ^dm;
        if (parity_mode == 2'b10) pb = ~pb;
        if (flip) pb = ~pb;
        exp_frames.push_back({bad_stop, par_on & flip, dm});
        sent_count++;
        db_s = data_bits; pm_s = parity_mode; s2_s = stop2;
        rx = 1'b0;
        step(bt / 2);
        if (scramble) begin
            data_bits   = 2'($urandom);
            parity_mode = 2'($urandom);
            stop2       = 1'($urandom);
        end
        step(bt - bt / 2);
        for (int i = 0; i < nb; i++) begin
            rx = dm[i];
            step(bt);
        end
        if (par_on) begin
            rx = pb;
            step(bt);
        end
        if (s2_s) begin
            rx = 1'b1;
            step(bt);
        end
        if (bad_stop) begin
            // low past the sample point, then an idle bit so the stray low is rejected as a false start
            rx = 1'b0;
            step(bt * 3 / 4);
            rx = 1'b1;
            step(bt - bt * 3 / 4 + bt);
        end else begin
            rx = 1'b1;
            step(bt);
        end
        data_bits = db_s; parity_mode = pm_s; stop2 = s2_s;
    endtask

    task automatic pop_check(input string nm, input logic [7:0] d, input logic pe, input logic fe);
        chk({nm, "_empty"}, 32'(rx_empty), 32'd0);
        chk({nm, "_data"},  32'(r_data),   32'(d));
        chk({nm, "_perr"},  32'(r_perr),   32'(pe));
        chk({nm, "_ferr"},  32'(r_ferr),   32'(fe));
        rd_uart = 1'b1;
        step(1);
        rd_uart = 1'b0;
    endtask

    // Pulse rd_uart so it is sampled on the same edge as the FIFO write of the next frame.
    task automatic rd_at_done(input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20000 && !got; k++) begin
            @(negedge clk);
            if (rx_done_tick) got = 1'b1;
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        #1 rd_uart = 1'b1;
        @(posedge clk);
        #1 rd_uart = 1'b0;
    endtask

    // Per-cycle compare against the queue model; model advances on each rising edge.
    initial begin : cmp
        logic       saw_done, have_w, rd_ok, drop;
        logic [9:0] w;
        int         was;
        forever begin
            @(negedge clk);
            chk("rx_empty", 32'(rx_empty), 32'(model_q.size() == 0));
            chk("rx_full",  32'(rx_full),  32'(model_q.size() == DEPTH));
            chk("overrun",  32'(overrun),  32'(model_ovr));
            if (model_q.size() != 0) begin
                chk("head_data", 32'(r_data), 32'(model_q[0][7:0]));
                chk("head_perr", 32'(r_perr), 32'(model_q[0][8]));
                chk("head_ferr", 32'(r_ferr), 32'(model_q[0][9]));
            end
            saw_done = rx_done_tick;
            have_w   = 1'b0;
            w        = '0;
            if (saw_done) begin
                done_count++;
                chk("done_has_frame", 32'(exp_frames.size() != 0), 32'd1);
                if (exp_frames.size() != 0) begin
                    w      = exp_frames.pop_front();
                    have_w = 1'b1;
                end
            end
            @(posedge clk);
            if (!reset_n) begin
                model_q.delete();
                exp_frames.delete();
                model_ovr = 1'b0;
            end else begin
                drop  = 1'b0;
                was   = model_q.size();
                rd_ok = rd_uart && (was != 0);
                if (rd_ok) void'(model_q.pop_front());
                if (have_w) begin
                    if (was < DEPTH || rd_ok) model_q.push_back(w);
                    else                      drop = 1'b1;
                end
                if (drop)         model_ovr = 1'b1;
                else if (clr_ovr) model_ovr = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        if (!finished) begin
            failures++;
            $display("FAIL watchdog actual=timeout required=finish");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin : main
        int bt, dc;
        // reset state
        reset_n = 1'b0;
        step(4);
        chk("rst_empty",   32'(rx_empty),     32'd1);
        chk("rst_full",    32'(rx_full),      32'd0);
        chk("rst_overrun", 32'(overrun),      32'd0);
        chk("rst_done",    32'(rx_done_tick), 32'd0);
        chk("rst_rdata",   32'({r_ferr, r_perr, r_data}), 32'd0);
        reset_n = 1'b1;
        step(4);

        // 8N1 at dvsr=10: four words fill the FIFO in order
        dvsr = 11'd10; data_bits = 2'b11; parity_mode = 2'b00; stop2 = 1'b0;
        bt = bit_time();
        send_frame(8'h7E, 0, 0, 0); step(bt / 4);
        send_frame(8'hFF, 0, 0, 0); step(bt / 4);
        send_frame(8'h81, 0, 0, 0); step(bt / 4);
        send_frame(8'hAA, 0, 0, 0); step(bt);
        chk("full_after_4", 32'(rx_full), 32'd1);
        chk("done_cnt_4",   32'(done_count), 32'd4);
        pop_check("w7E", 8'h7E, 0, 0);
        pop_check("wFF", 8'hFF, 0, 0);
        pop_check("w81", 8'h81, 0, 0);
        pop_check("wAA", 8'hAA, 0, 0);
        chk("empty_after_pops", 32'(rx_empty), 32'd1);

        // 5E2: correct parity, then flipped parity
        dvsr = 11'd4; data_bits = 2'b00; parity_mode = 2'b01; stop2 = 1'b1;
        bt = bit_time();
        send_frame(8'h15, 0, 0, 0); step(bt / 2);
        send_frame(8'h15, 1, 0, 0); step(bt);
        pop_check("e2_ok",  8'h15, 0, 0);
        pop_check("e2_bad", 8'h15, 1, 0);

        // 7O1: broken stop bit, then a clean frame
        data_bits = 2'b10; parity_mode = 2'b10; stop2 = 1'b0;
        send_frame(8'h41, 0, 1, 0); step(bt / 2);
        send_frame(8'h3C, 0, 0, 0); step(bt);
        pop_check("o1_ferr",  8'h41, 0, 1);
        pop_check("o1_clean", 8'h3C, 0, 0);

        // overrun: five frames into a four-deep FIFO
        data_bits = 2'b11; parity_mode = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 0, 0, 0);
            step(bt / 4);
        end
        step(bt);
        chk("ovr_full",  32'(rx_full), 32'd1);
        chk("ovr_set",   32'(overrun), 32'd1);
        clr_ovr = 1'b1; step(1); clr_ovr = 1'b0;
        chk("ovr_clr",   32'(overrun), 32'd0);
        // write and read on the same edge while full
        fork
            send_frame(8'h06, 0, 0, 0);
            rd_at_done("full_wr_rd");
        join
        step(bt);
        chk("full_wr_rd_full", 32'(rx_full), 32'd1);
        chk("full_wr_rd_ovr",  32'(overrun), 32'd0);
        pop_check("q2", 8'h02, 0, 0);
        pop_check("q3", 8'h03, 0, 0);
        pop_check("q4", 8'h04, 0, 0);
        pop_check("q6", 8'h06, 0, 0);
        // read while empty does nothing
        rd_uart = 1'b1; step(1); rd_uart = 1'b0; step(1);
        chk("rd_empty_noop", 32'(rx_empty), 32'd1);
        // write and read on the same edge while empty
        fork
            send_frame(8'h5A, 0, 0, 0);
            rd_at_done("empty_wr_rd");
        join
        step(bt);
        chk("empty_wr_rd_kept", 32'(rx_empty), 32'd0);
        pop_check("w5A", 8'h5A, 0, 0);

        // short low glitch is a false start
        dc = done_count;
        rx = 1'b0; step(5 * (int'(dvsr) + 1));
        rx = 1'b1; step(3 * bt);
        chk("glitch_empty", 32'(rx_empty), 32'd1);
        chk("glitch_nodone", 32'(done_count), 32'(dc));

        // reset in the middle of the data bits, then a clean frame
        rx = 1'b0; step(bt);
        rx = 1'b1; step(bt);
        rx = 1'b0; step(bt / 2);
        reset_n = 1'b0; rx = 1'b1;
        step(3);
        chk("midrst_empty", 32'(rx_empty), 32'd1);
        reset_n = 1'b1;
        step(2 * bt);
        chk("midrst_nodone", 32'(done_count), 32'(dc));
        send_frame(8'hC3, 0, 0, 0); step(bt);
        pop_check("after_rst", 8'hC3, 0, 0);

        // random configs, errors, reads and clears
        rand_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    dvsr        = 11'($urandom_range(2, 5));
                    data_bits   = 2'($urandom);
                    parity_mode = 2'($urandom);
                    stop2       = 1'($urandom);
                    send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 1'b1);
                    step($urandom_range(0, 40));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    rd_uart = ($urandom_range(0, 1199) == 0);
                    clr_ovr = ($urandom_range(0, 2999) == 0);
                    step(1);
                end
                rd_uart = 1'b0;
                clr_ovr = 1'b0;
            end
        join
        step(2 * bit_time());
        for (int k = 0; k < 2 * DEPTH; k++) begin
            if (!rx_empty) begin
                rd_uart = 1'b1; step(1); rd_uart = 1'b0; step(1);
            end
        end
        step(4);
        chk("end_pending", 32'(exp_frames.size()), 32'd0);
        chk("end_done_cnt", 32'(done_count), 32'(sent_count));
        chk("end_empty", 32'(rx_empty), 32'd1);

        finished = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
